// File: rtl/spi_peripheral_if.sv
// Byte-wide device side plus SPI pin side of the SPI responder.
// The slave modport is the peripheral's view; the master modport is the view of whoever drives it.
interface spi_peripheral_if;
  logic [2:0] i_config;
  logic [7:0] i_tx;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx;
  logic       o_rx_valid;
  logic       o_busy;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_copi;
  logic       o_cipo;
  logic       o_cipo_en;

  modport slave (
    input  i_config, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    output o_tx_ready, o_rx, o_rx_valid, o_busy, o_cipo, o_cipo_en
  );

  modport master (
    output i_config, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    input  o_tx_ready, o_rx, o_rx_valid, o_busy, o_cipo, o_cipo_en
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI responder, modes 0-3, oversampling SCLK/CS_N/COPI in the i_clk domain.
// One TX holding register feeds the shift register at every byte start.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_peripheral_if.slave   bus
);

  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, copi_sync_q;
  logic sclk_s, cs_s, copi_s;
  logic sclk_last_q, cs_last_q, copi_q;
  logic rise_q, fall_q, cs_fall_q, cs_rise_q;

  logic [1:0] mode_q, mode_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic       rx_valid_q, rx_valid_d;
  logic       cipo_q, cipo_d;

  logic cpol, cpha, lead_edge, trail_edge, sample_edge, drive_edge;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // Edge events are registered so every pin edge reaches the FSM a fixed SYNC_STAGES+1 cycles later
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b1;
      copi_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.i_copi};
      sclk_last_q <= sclk_s;
      cs_last_q   <= cs_s;
      copi_q      <= copi_s;
      rise_q      <= sclk_s & ~sclk_last_q;
      fall_q      <= ~sclk_s & sclk_last_q;
      cs_fall_q   <= ~cs_s & cs_last_q;
      cs_rise_q   <= cs_s & ~cs_last_q;
    end
  end

  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign lead_edge   = cpol ? fall_q : rise_q;
  assign trail_edge  = cpol ? rise_q : fall_q;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge : trail_edge;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    rx_valid_d = 1'b0;
    cipo_d     = cipo_q;

    if (bus.i_tx_valid && !tx_full_q) begin
      tx_hold_d = bus.i_tx;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_RESET: begin
        cipo_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cipo_d    = 1'b0;
        bit_cnt_d = 3'd0;
        if (bus.i_config[0]) mode_d = bus.i_config[2:1];
        if (cs_fall_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_sh_d   = tx_full_q ? tx_hold_q : 8'h00;
        cipo_d    = tx_full_q ? tx_hold_q[7] : 1'b0;
        if (tx_full_q) tx_full_d = 1'b0;
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sample_edge) begin
          if (bit_cnt_q == 3'd7) begin
            rx_d       = {rx_sh_q, copi_q};
            rx_valid_d = 1'b1;
            state_d    = ST_LOAD;
          end else begin
            rx_sh_d   = {rx_sh_q[5:0], copi_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (drive_edge) begin
          // With no sample yet in this byte the drive edge either re-drives bit 7 (CPHA=1)
          // or is the tail of the previous byte's last bit (CPHA=0) and must not shift.
          if (bit_cnt_q == 3'd0) begin
            if (cpha) cipo_d = tx_sh_q[7];
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            cipo_d  = tx_sh_q[6];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_rise_q && (state_q == ST_LOAD || state_q == ST_SHIFT)) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      cipo_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RESET;
      mode_q     <= 2'd0;
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 7'h00;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      rx_valid_q <= 1'b0;
      cipo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      cipo_q     <= cipo_d;
    end
  end

  assign bus.o_tx_ready = ~tx_full_q;
  assign bus.o_rx       = rx_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_busy     = ~cs_last_q;
  assign bus.o_cipo     = cipo_q;
  assign bus.o_cipo_en  = ~cs_last_q && (state_q == ST_LOAD || state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a behavioural SPI controller drives the pins,
// a monitor logs o_rx_valid pulses, and each step asserts against hand-computed values.
module tb_spi_peripheral;
  localparam int SYNC = 2;
  localparam int H    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_peripheral_if bus();

  spi_peripheral #(.SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rxv_cnt = 0;
  int         rxv_cyc = 0;
  logic [7:0] rx_log [0:15];
  logic       prev_v = 1'b0;
  logic       wide_seen = 1'b0;

  always @(negedge clk) begin
    prev_v <= bus.o_rx_valid;
    if (bus.o_rx_valid) begin
      if (prev_v) wide_seen <= 1'b1;
      rx_log[rxv_cnt[3:0]] <= bus.o_rx;
      rxv_cnt <= rxv_cnt + 1;
      rxv_cyc <= cyc;
    end
  end

  logic [1:0] tb_mode = 2'd0;
  int         last_samp_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    bus.i_config = {m, 1'b1};
    @(negedge clk);
    bus.i_config = 3'b000;
    tb_mode = m;
    bus.i_sclk = m[1];
    tick(H);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    bus.i_tx = b;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.i_cs_n = 1'b0;
    tick(H);
  endtask

  task automatic cs_high();
    tick(H);
    bus.i_cs_n = 1'b1;
    tick(2 * H);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!tb_mode[0]) begin
        bus.i_copi = mo[i];
        tick(H);
        mi[i] = bus.o_cipo;
        bus.i_sclk = ~tb_mode[1];
        last_samp_cyc = cyc;
        tick(H);
        bus.i_sclk = tb_mode[1];
      end else begin
        bus.i_sclk = ~tb_mode[1];
        bus.i_copi = mo[i];
        tick(H);
        mi[i] = bus.o_cipo;
        bus.i_sclk = tb_mode[1];
        last_samp_cyc = cyc;
        tick(H);
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int         base;
    logic [7:0] cipo_exp [0:3];
    cipo_exp[0] = 8'h00;

    rst = 1'b1;
    bus.i_config = 3'b000;
    bus.i_tx = 8'h00;
    bus.i_tx_valid = 1'b0;
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_copi = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_rx", bus.o_rx, 8'h00);
    check("rst_rx_valid", bus.o_rx_valid, 1'b0);
    check("rst_tx_ready", bus.o_tx_ready, 1'b1);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_cipo", bus.o_cipo, 1'b0);
    check("rst_cipo_en", bus.o_cipo_en, 1'b0);
    tick(3);

    // Mode 0 single byte
    push_tx(8'h3C);
    check("m0_ready_low", bus.o_tx_ready, 1'b0);
    base = rxv_cnt;
    cs_low();
    check("m0_ready_after_load", bus.o_tx_ready, 1'b1);
    check("m0_busy", bus.o_busy, 1'b1);
    check("m0_cipo_en", bus.o_cipo_en, 1'b1);
    spi_byte(8'hA5, 8, mi);
    check("m0_rx", bus.o_rx, 8'hA5);
    check("m0_cipo_byte", mi, 8'h3C);
    check("m0_pulses", rxv_cnt - base, 1);
    check("m0_rxv_latency", rxv_cyc - last_samp_cyc, SYNC + 2);
    cs_high();
    check("m0_busy_idle", bus.o_busy, 1'b0);

    // Modes 1..3 round trip
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      push_tx(8'h5A);
      base = rxv_cnt;
      cs_low();
      spi_byte(8'h96, 8, mi);
      check($sformatf("m%0d_rx", m), bus.o_rx, 8'h96);
      check($sformatf("m%0d_cipo_byte", m), mi, 8'h5A);
      check($sformatf("m%0d_pulses", m), rxv_cnt - base, 1);
      check($sformatf("m%0d_rxv_latency", m), rxv_cyc - last_samp_cyc, SYNC + 2);
      cs_high();
      check($sformatf("m%0d_cipo_en_idle", m), bus.o_cipo_en, 1'b0);
    end

    // Two-byte burst in mode 0, second TX byte written after the first LOAD
    set_mode(2'd0);
    push_tx(8'h77);
    base = rxv_cnt;
    cs_low();
    push_tx(8'h81);
    spi_byte(8'h01, 8, mi);
    spi_byte(8'hFE, 8, mi2);
    cs_high();
    check("burst_pulses", rxv_cnt - base, 2);
    check("burst_rx0", rx_log[base[3:0]], 8'h01);
    check("burst_rx1", rx_log[base[3:0] + 4'd1], 8'hFE);
    check("burst_cipo0", mi, 8'h77);
    check("burst_cipo1", mi2, 8'h81);

    // TX underrun
    base = rxv_cnt;
    cs_low();
    spi_byte(8'h3E, 8, mi);
    cs_high();
    check("underrun_cipo", mi, cipo_exp[0]);
    check("underrun_rx", bus.o_rx, 8'h3E);
    check("underrun_pulses", rxv_cnt - base, 1);

    // Partial byte then a full one
    push_tx(8'h24);
    base = rxv_cnt;
    cs_low();
    spi_byte(8'h55, 5, mi);
    cs_high();
    check("partial_pulses", rxv_cnt - base, 0);
    check("partial_rx_kept", bus.o_rx, 8'h3E);
    check("partial_ready", bus.o_tx_ready, 1'b1);
    push_tx(8'h99);
    cs_low();
    spi_byte(8'hC3, 8, mi);
    cs_high();
    check("after_partial_rx", bus.o_rx, 8'hC3);
    check("after_partial_cipo", mi, 8'h99);
    check("after_partial_pulses", rxv_cnt - base, 1);

    // Config strobe during CS is ignored, in IDLE it applies
    push_tx(8'h5A);
    cs_low();
    @(negedge clk);
    bus.i_config = 3'b111;
    @(negedge clk);
    bus.i_config = 3'b000;
    spi_byte(8'h6B, 8, mi);
    cs_high();
    check("cfg_busy_rx", bus.o_rx, 8'h6B);
    check("cfg_busy_cipo", mi, 8'h5A);
    set_mode(2'd3);
    push_tx(8'h3C);
    cs_low();
    spi_byte(8'hC3, 8, mi);
    cs_high();
    check("cfg_idle_rx", bus.o_rx, 8'hC3);
    check("cfg_idle_cipo", mi, 8'h3C);

    // Reset mid-byte
    set_mode(2'd0);
    push_tx(8'h11);
    cs_low();
    push_tx(8'h22);
    spi_byte(8'hF0, 4, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx", bus.o_rx, 8'h00);
    check("midrst_rx_valid", bus.o_rx_valid, 1'b0);
    check("midrst_tx_ready", bus.o_tx_ready, 1'b1);
    check("midrst_busy", bus.o_busy, 1'b0);
    check("midrst_cipo", bus.o_cipo, 1'b0);
    check("midrst_cipo_en", bus.o_cipo_en, 1'b0);
    cs_high();
    push_tx(8'hE7);
    base = rxv_cnt;
    cs_low();
    spi_byte(8'h3C, 8, mi);
    cs_high();
    check("postrst_rx", bus.o_rx, 8'h3C);
    check("postrst_cipo", mi, 8'hE7);
    check("postrst_pulses", rxv_cnt - base, 1);

    check("rx_valid_width", wide_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
